mem_responder: RTL

Responder (slave) end of the CPU memory bus: accepts single read/write requests from the memory controller through a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write acknowledge through a held response channel. It owns the word-addressed 32-bit storage array and sits between the controller's address/data/RW outputs and the data-input path back to the register file.

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_array.sv | 18 +
 rtl/mem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-bus types and constants for the responder and the memory controller.
package mem_pkg;
   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
   localparam logic MEM_RW_READ  = 1'b0;
   localparam logic MEM_RW_WRITE = 1'b1;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W word storage with one synchronous write port and one combinational read port.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory-bus responder with programmable wait states and a held response.
// Define MEM_RESP_CLEAR_EN to zero the whole array in a CLEAR sweep after every reset release.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   state_t state;
   logic [3:0] cnt;
   logic op_rw;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_wdata;
   logic accept, enter_resp, cur_rw, cur_err, arr_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata, arr_wdata, arr_rdata;
   logic [AW-1:0] arr_waddr;
   assign accept = req_valid && req_ready;
   // With zero wait states the access happens on the accept edge itself, so it must use the live request.
   assign cur_rw     = (state == IDLE) ? req_rw : op_rw;
   assign cur_addr   = (state == IDLE) ? req_addr : op_addr;
   assign cur_wdata  = (state == IDLE) ? req_wdata : op_wdata;
   assign cur_err    = 32'(cur_addr) >= 32'(DEPTH);
   assign enter_resp = (state == IDLE && accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
`ifdef MEM_RESP_CLEAR_EN
   localparam state_t START = CLEAR;
   logic [AW-1:0] clr_addr;
   assign arr_we    = (state == CLEAR) || (enter_resp && cur_rw == MEM_RW_WRITE && !cur_err);
   assign arr_waddr = (state == CLEAR) ? clr_addr : cur_addr[AW-1:0];
   assign arr_wdata = (state == CLEAR) ? '0 : cur_wdata;
   always_ff @(posedge clk or negedge rst)
      if (!rst) clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
`else
   localparam state_t START = IDLE;
   assign arr_we    = enter_resp && cur_rw == MEM_RW_WRITE && !cur_err;
   assign arr_waddr = cur_addr[AW-1:0];
   assign arr_wdata = cur_wdata;
`endif
   mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk  (clk),
      .we   (arr_we),
      .waddr(arr_waddr),
      .wdata(arr_wdata),
      .raddr(cur_addr[AW-1:0]),
      .rdata(arr_rdata)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= START;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= 4'd0;
         op_rw     <= MEM_RW_READ;
         op_addr   <= '0;
         op_wdata  <= '0;
      end else begin
         case (state)
`ifdef MEM_RESP_CLEAR_EN
            CLEAR: if (clr_addr == AW'(DEPTH - 1)) begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
`endif
            IDLE: begin
               req_ready <= !accept;
               if (accept) begin
                  op_rw    <= req_rw;
                  op_addr  <= req_addr;
                  op_wdata <= req_wdata;
                  cnt      <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
                  state    <= WAIT_CYCLES > 0 ? WAIT : RESP;
               end
            end
            WAIT: begin
               cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
               state <= cnt == 4'd0 ? RESP : WAIT;
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_rdata <= (!cur_err && cur_rw == MEM_RW_READ) ? arr_rdata : '0;
         end
      end
   end
endmodule
